// File: rtl/ped_crossing_ctrl_v2.sv
// Pedestrian crossing controller: timed car/pedestrian phases, request latch,
// flashing pedestrian clearance and an unattended flashing-yellow night mode.
module ped_crossing_ctrl_v2 #(
    parameter int unsigned T_MIN_GREEN  = 500000000,
    parameter int unsigned T_YELLOW     = 100000000,
    parameter int unsigned T_PED_GREEN  = 200000000,
    parameter int unsigned T_PED_FLASH  = 100000000,
    parameter int unsigned T_RED_YELLOW = 100000000,
    parameter int unsigned FLASH_HALF   = 25000000,
    parameter int unsigned CNT_W        = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       night_mode,
    output logic       road_red,
    output logic       road_yellow,
    output logic       road_green,
    output logic       ped_red,
    output logic       ped_green,
    output logic       ped_wait,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        CARS_GREEN      = 3'd0,
        CARS_YELLOW     = 3'd1,
        PED_GREEN       = 3'd2,
        PED_FLASH       = 3'd3,
        CARS_RED_YELLOW = 3'd4,
        NIGHT           = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] PG_LAST = CNT_W'(T_PED_GREEN - 1);
    localparam logic [CNT_W-1:0] PF_LAST = CNT_W'(T_PED_FLASH - 1);
    localparam logic [CNT_W-1:0] RY_LAST = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic [CNT_W-1:0] fcnt, fcnt_next;
    logic             req, req_next;
    logic             flash, flash_next;
    logic             changed;
    logic             rr_n, ry_n, rg_n, pr_n, pg_n;

    always_comb begin
        state_next = state;
        case (state)
            CARS_GREEN: begin
                if (night_mode)
                    state_next = NIGHT;
                else if (req && timer == MG_LAST)
                    state_next = CARS_YELLOW;
            end
            CARS_YELLOW:     if (timer == Y_LAST)  state_next = PED_GREEN;
            PED_GREEN:       if (timer == PG_LAST) state_next = PED_FLASH;
            PED_FLASH:       if (timer == PF_LAST) state_next = CARS_RED_YELLOW;
            CARS_RED_YELLOW: if (timer == RY_LAST) state_next = CARS_GREEN;
            NIGHT:           if (!night_mode)      state_next = CARS_RED_YELLOW;
            default:         state_next = CARS_GREEN;
        endcase
    end

    always_comb begin
        changed = (state_next != state);

        // Green holds at its last count so a late request leaves on the next edge.
        timer_next = timer + ONE;
        if (changed)
            timer_next = '0;
        else if (state == CARS_GREEN && timer == MG_LAST)
            timer_next = timer;

        req_next = req;
        if (changed && (state_next == PED_GREEN || state_next == NIGHT))
            req_next = 1'b0;
        else if (ped_btn && (state inside {CARS_GREEN, CARS_YELLOW, PED_FLASH, CARS_RED_YELLOW}))
            req_next = 1'b1;

        fcnt_next  = fcnt;
        flash_next = flash;
        if (changed && (state_next == PED_FLASH || state_next == NIGHT)) begin
            fcnt_next  = '0;
            flash_next = 1'b1;
        end else if (state == PED_FLASH || state == NIGHT) begin
            if (fcnt == FH_LAST) begin
                fcnt_next  = '0;
                flash_next = ~flash;
            end else begin
                fcnt_next = fcnt + ONE;
            end
        end
    end

    // Lamps are decoded from the next state and registered with it, so they
    // carry no extra latency and cannot glitch across a phase boundary.
    always_comb begin
        rr_n = 1'b0;
        ry_n = 1'b0;
        rg_n = 1'b0;
        pr_n = 1'b0;
        pg_n = 1'b0;
        case (state_next)
            CARS_GREEN:      begin rg_n = 1'b1; pr_n = 1'b1; end
            CARS_YELLOW:     begin ry_n = 1'b1; pr_n = 1'b1; end
            PED_GREEN:       begin rr_n = 1'b1; pg_n = 1'b1; end
            PED_FLASH:       begin rr_n = 1'b1; pg_n = flash_next; end
            CARS_RED_YELLOW: begin rr_n = 1'b1; ry_n = 1'b1; pr_n = 1'b1; end
            NIGHT:           ry_n = flash_next;
            default:         begin rg_n = 1'b1; pr_n = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CARS_GREEN;
            timer       <= '0;
            fcnt        <= '0;
            req         <= 1'b0;
            flash       <= 1'b0;
            road_red    <= 1'b0;
            road_yellow <= 1'b0;
            road_green  <= 1'b1;
            ped_red     <= 1'b1;
            ped_green   <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            fcnt        <= fcnt_next;
            req         <= req_next;
            flash       <= flash_next;
            road_red    <= rr_n;
            road_yellow <= ry_n;
            road_green  <= rg_n;
            ped_red     <= pr_n;
            ped_green   <= pg_n;
        end
    end

    assign ped_wait    = req;
    assign debug_state = state;

endmodule

// File: tb/tb_ped_crossing_ctrl_v2.sv
// Scoreboard bench for ped_crossing_ctrl_v2: a phase-level reference model
// predicts every cycle's lamps/state/request, compared on the falling edge.
module tb_ped_crossing_ctrl_v2;

    localparam int MG  = 8;
    localparam int TY  = 3;
    localparam int TPG = 5;
    localparam int TPF = 4;
    localparam int FH  = 2;
    localparam int TRY = 2;

    localparam int S_GREEN = 0, S_YELLOW = 1, S_PG = 2, S_PF = 3, S_RY = 4, S_NIGHT = 5;
    localparam logic [8:0] RESET_VEC = 9'b000_001_100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ped_btn = 1'b0;
    logic       night_mode = 1'b0;
    logic       road_red, road_yellow, road_green, ped_red, ped_green, ped_wait;
    logic [2:0] debug_state;
    logic [8:0] obs;
    logic [8:0] mon_exp;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [8:0] exp_q[$];
    string phase = "init";

    int ms;
    int mn;
    bit mreq;

    ped_crossing_ctrl_v2 #(
        .T_MIN_GREEN (MG),
        .T_YELLOW    (TY),
        .T_PED_GREEN (TPG),
        .T_PED_FLASH (TPF),
        .T_RED_YELLOW(TRY),
        .FLASH_HALF  (FH),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_btn    (ped_btn),
        .night_mode (night_mode),
        .road_red   (road_red),
        .road_yellow(road_yellow),
        .road_green (road_green),
        .ped_red    (ped_red),
        .ped_green  (ped_green),
        .ped_wait   (ped_wait),
        .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    assign obs = {debug_state, road_red, road_yellow, road_green, ped_red, ped_green, ped_wait};

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b required %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_out();
        bit fl;
        bit rr, ry, rg, pr, pg;
        fl = ((mn / FH) % 2) == 0;
        {rr, ry, rg, pr, pg} = 5'b0;
        case (ms)
            S_GREEN:  begin rg = 1; pr = 1; end
            S_YELLOW: begin ry = 1; pr = 1; end
            S_PG:     begin rr = 1; pg = 1; end
            S_PF:     begin rr = 1; pg = fl; end
            S_RY:     begin rr = 1; ry = 1; pr = 1; end
            default:  ry = fl;
        endcase
        return {3'(ms), rr, ry, rg, pr, pg, mreq};
    endfunction

    function automatic void model_reset();
        ms   = S_GREEN;
        mn   = 0;
        mreq = 0;
    endfunction

    function automatic void model_step(input bit b, input bit nm);
        int nxt;
        nxt = ms;
        case (ms)
            S_GREEN:  if (nm) nxt = S_NIGHT; else if (mreq && mn >= MG - 1) nxt = S_YELLOW;
            S_YELLOW: if (mn == TY - 1)  nxt = S_PG;
            S_PG:     if (mn == TPG - 1) nxt = S_PF;
            S_PF:     if (mn == TPF - 1) nxt = S_RY;
            S_RY:     if (mn == TRY - 1) nxt = S_GREEN;
            default:  if (!nm) nxt = S_RY;
        endcase
        if (nxt != ms && (nxt == S_PG || nxt == S_NIGHT))
            mreq = 0;
        else if (b && ms != S_PG && ms != S_NIGHT)
            mreq = 1;
        mn = (nxt != ms) ? 0 : mn + 1;
        ms = nxt;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check(phase, obs, mon_exp);
        end
    end

    task automatic step(input bit b, input bit nm);
        ped_btn    = b;
        night_mode = nm;
        @(posedge clk);
        model_step(b, nm);
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic do_reset(input string tag);
        phase      = tag;
        ped_btn    = 0;
        night_mode = 0;
        rst        = 1;
        #1;
        model_reset();
        check({tag, "_async"}, obs, RESET_VEC);
        @(posedge clk);
        #1;
        check({tag, "_held"}, obs, RESET_VEC);
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic run_until(input int st, input int cyc);
        for (int i = 0; i < 100; i++) begin
            if (ms == st && mn == cyc) return;
            step(0, 0);
        end
        check({phase, "_timeout"}, 9'd0, 9'd1);
    endtask

    initial begin
        // Idle after reset: green stays
        do_reset("idle");
        idle(20);

        // Single press at cycle 2: full pedestrian cycle
        do_reset("ped_cycle");
        idle(2);
        step(1, 0);
        idle(30);

        // Press in PED_GREEN ignored; press in CARS_RED_YELLOW queues a new cycle
        do_reset("press_pg_ry");
        step(1, 0);
        run_until(S_PG, 1);
        step(1, 0);
        run_until(S_RY, 0);
        step(1, 0);
        idle(30);

        // Late press after long green leaves green on the next cycle
        do_reset("late_press");
        idle(20);
        step(1, 0);
        idle(6);

        // Night mode with pending request
        do_reset("night");
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 6; i++) step(0, 1);
        idle(12);

        // Asynchronous reset in the middle of PED_GREEN
        do_reset("mid_reset");
        step(1, 0);
        run_until(S_PG, 2);
        rst = 1;
        #1;
        model_reset();
        check("mid_reset_async", obs, RESET_VEC);
        check("mid_reset_pg_off", 9'(ped_green), 9'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        phase = "after_reset";
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
